// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART 8N1 transmitter with a small byte FIFO ahead of the shifter
module uart_tx #(
    parameter int CLK_PER_BIT = 10417,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [13:0]   BIT_LAST   = 14'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e        state_q, state_d;
    logic [13:0]   clk_count_q, clk_count_d;
    logic [2:0]    bit_index_q, bit_index_d;
    logic [2:0]    bit_next;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push, pop, fifo_empty, bit_done;

    assign fifo_empty = (count_q == '0);
    assign ready      = (count_q != FULL_COUNT) && !rst;
    assign push       = valid && ready;
    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign tx         = tx_q;
    assign bit_done   = (clk_count_q == BIT_LAST);
    assign bit_next   = bit_index_q + 3'd1;

    // A full FIFO refuses a push even when the shifter pops in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            clk_count_q <= '0;
            bit_index_q <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            clk_count_q <= clk_count_d;
            bit_index_q <= bit_index_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
        end
    end

    // tx_d is always the value of the line for the next cycle, so tx leaves a flop.
    always_comb begin
        state_d     = state_q;
        clk_count_d = clk_count_q;
        bit_index_d = bit_index_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    shift_d     = mem_q[rd_ptr_q];
                    clk_count_d = '0;
                    tx_d        = 1'b0;
                    state_d     = START;
                end
            end
            START: begin
                if (bit_done) begin
                    clk_count_d = '0;
                    tx_d        = shift_q[0];
                    bit_index_d = '0;
                    state_d     = DATA;
                end else begin
                    clk_count_d = clk_count_q + 14'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    clk_count_d = '0;
                    if (bit_index_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_index_d = bit_next;
                        tx_d        = shift_q[bit_next];
                    end
                end else begin
                    clk_count_d = clk_count_q + 14'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    clk_count_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    clk_count_d = clk_count_q + 14'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx with a mid-bit sampling receiver
module tb_uart_tx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       ready, tx, busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int framing_errs = 0;

    logic [7:0] rx_q[$];
    int         starts[$];

    uart_tx #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rx_at(input int i);
        if (rx_q.size() > i) return rx_q[i];
        return 8'hxx;
    endfunction

    task automatic wait_rx(input int n, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (rx_q.size() >= n) break;
            tick();
        end
    endtask

    task automatic wait_idle(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            if (!busy) begin
                at = cyc;
                break;
            end
            tick();
        end
    endtask

    // Independent receiver: start at first low sample, data sampled mid-bit, frame dropped on reset.
    initial begin
        int         off;
        int         st;
        logic [7:0] b;
        bit         active;
        active = 1'b0;
        off    = 0;
        st     = 0;
        b      = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    active = 1'b1;
                    off    = 0;
                    st     = cyc;
                end
            end else begin
                off++;
                if (off == 8 && tx !== 1'b0) begin
                    active = 1'b0;
                end else if (off >= 24 && off <= 136 && ((off - 24) % 16) == 0) begin
                    b[3'((off - 24) / 16)] = tx;
                end else if (off == 152) begin
                    if (tx === 1'b1) begin
                        rx_q.push_back(b);
                        starts.push_back(st);
                    end else begin
                        framing_errs++;
                    end
                end else if (off == 159) begin
                    active = 1'b0;
                end
            end
        end
    end

    initial begin
        int         errs;
        int         at;
        int         accepts;
        int         first_block;
        int         ret_cyc;
        bit         acc;
        logic [9:0] frame;
        logic [7:0] burst [4];

        burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h55; burst[3] = 8'h3C;

        // reset and idle
        tick(); tick(); tick();
        check_eq("rst_ready", ready, 1'b0);
        check_eq("rst_tx", tx, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        rst = 1'b0;
        #1;
        check_eq("ready_after_rst", ready, 1'b1);
        errs = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) errs++;
            tick();
        end
        check_eq("idle_hold", errs, 0);

        // single byte 0xA5: exact waveform
        rx_q.delete(); starts.delete();
        data = 8'hA5; valid = 1'b1;
        tick();
        valid = 1'b0;
        check_eq("a5_tx_n1", tx, 1'b1);
        check_eq("a5_busy_n1", busy, 1'b1);
        tick();
        check_eq("a5_tx_low_n2", tx, 1'b0);
        frame = {1'b1, 8'hA5, 1'b0};
        errs = 0;
        for (int k = 0; k < 160; k++) begin
            if (tx !== frame[k / 16]) errs++;
            if (k == 159) check_eq("a5_busy_last", busy, 1'b1);
            tick();
        end
        check_eq("a5_wave", errs, 0);
        check_eq("a5_busy_end", busy, 1'b0);
        check_eq("a5_tx_end", tx, 1'b1);
        check_eq("a5_rx_cnt", rx_q.size(), 1);
        check_eq("a5_rx", rx_at(0), 8'hA5);

        // four bytes on consecutive cycles, back-to-back frames
        rx_q.delete(); starts.delete();
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            data = burst[i]; valid = 1'b1;
            if (ready !== 1'b1) errs++;
            tick();
        end
        valid = 1'b0;
        check_eq("burst_accept", errs, 0);
        wait_idle(900, at);
        wait_rx(4, 20);
        check_eq("burst_rx_cnt", rx_q.size(), 4);
        for (int i = 0; i < 4; i++) check_eq($sformatf("burst_rx%0d", i), rx_at(i), burst[i]);
        if (starts.size() == 4) begin
            for (int i = 0; i < 3; i++)
                check_eq($sformatf("burst_gap%0d", i), starts[i + 1] - starts[i], 160);
            check_eq("burst_total", at - starts[0], 640);
        end

        // hold valid while the FIFO fills
        rx_q.delete(); starts.delete();
        accepts = 0; first_block = -1; ret_cyc = -1;
        data = 8'h11; valid = 1'b1;
        for (int c = 0; c < 400 && accepts < 6; c++) begin
            acc = ready;
            if (!acc && first_block < 0) first_block = accepts;
            if (acc && first_block >= 0 && ret_cyc < 0) ret_cyc = cyc;
            if (acc) accepts++;
            tick();
            if (acc) data = data + 8'h01;
        end
        valid = 1'b0;
        check_eq("fill_accepts", accepts, 6);
        check_eq("fill_block_at", first_block, 5);
        check_eq("full_again", ready, 1'b0);
        wait_rx(6, 1200);
        check_eq("fill_rx_cnt", rx_q.size(), 6);
        for (int i = 0; i < 6; i++) check_eq($sformatf("fill_rx%0d", i), rx_at(i), 8'h11 + 8'(i));
        if (starts.size() >= 2) check_eq("fill_ready_return", ret_cyc, starts[1]);
        wait_idle(300, at);

        // reset in the middle of 0xC3 with two bytes queued
        rx_q.delete(); starts.delete();
        data = 8'hC3; valid = 1'b1; tick();
        data = 8'h01; tick();
        data = 8'h02; tick();
        valid = 1'b0;
        for (int i = 0; i < 10 && tx !== 1'b0; i++) tick();
        check_eq("c3_started", tx, 1'b0);
        for (int i = 0; i < 56; i++) tick();
        rst = 1'b1;
        tick();
        check_eq("mid_rst_tx", tx, 1'b1);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_ready", ready, 1'b0);
        rst = 1'b0;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b0 || tx !== 1'b1) errs++;
            tick();
        end
        check_eq("post_rst_idle", errs, 0);
        data = 8'h7E; valid = 1'b1; tick();
        valid = 1'b0;
        wait_rx(1, 300);
        for (int i = 0; i < 200; i++) tick();
        check_eq("post_rst_rx_cnt", rx_q.size(), 1);
        check_eq("post_rst_rx", rx_at(0), 8'h7E);
        check_eq("framing_errs", framing_errs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
